// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rr_arbiter_8_pkg;

    localparam int N            = 8;  // requesters
    localparam int IDW          = 3;  // grant index width, log2(N)
    localparam int MAX_HOLD_DEF = 4;  // default hold limit, 0 = unlimited

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Binary index to one-hot grant vector.
    function automatic logic [N-1:0] id_to_onehot(input logic [IDW-1:0] id);
        return N'(1) << id;
    endfunction

endpackage

// File: rtl/rr_prio_pick_8.sv
// Rotating priority picker: first set req bit at or after start, wrapping 7->0.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
//
// Ports:
//   req   [7:0] candidate request vector
//   start [2:0] index with highest priority
//   found       any candidate present
//   idx   [2:0] index of the winning candidate (0 when none found)
module rr_prio_pick_8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] enc;

    // Rotate so that bit 'start' lands on position 0; the 3-bit index sum
    // wraps naturally modulo 8.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDW'(i) + start];
        end
    end

    // Fixed-priority encode, lowest position wins.
    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDW'(i);
            end
        end
    end

    assign found = |rot;
    // Undo the rotation; only meaningful when found is high.
    assign idx   = found ? enc + start : '0;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a bounded grant hold time.
// Latency: 1 clock from req sampled to registered gnt/gnt_id/gnt_valid.
// Backpressure: en low blocks new grants and preemption; the current owner keeps its grant until it drops req.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         arbitration enable
//   req  [7:0] request vector, bit i = requester i
//   gnt  [7:0] registered one-hot grant, zero when idle
//   gnt_id[2:0] binary index of the granted bit, zero when idle
//   gnt_valid  high while a grant is active
//
// N and IDW come from the package; only the hold limit is tunable here.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    // The hold counter only has to reach MAX_HOLD-1.
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;

    logic [N-1:0]   cand;
    logic [IDW-1:0] pick_start;
    logic [IDW-1:0] win;
    logic           found;
    logic           owner_req;
    logic           hold_up;

    // Masking out the owner serves both the release case (its req is already
    // zero) and the preempt case (the owner must never win its own rotation).
    assign cand       = req & ~gnt;
    // While granting, the search starts just past the owner; when idle it
    // starts from the pointer left by the last release/preempt.
    assign pick_start = (state == ST_GRANT) ? gnt_id + IDW'(1) : ptr;
    assign owner_req  = |(req & gnt);
    assign hold_up    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    rr_prio_pick_8 u_pick (
        .req   (cand),
        .start (pick_start),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && found) begin
                        gnt       <= id_to_onehot(win);
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (!owner_req) begin
                        // Release: move priority past the old owner and hand
                        // over without a bubble if anyone else is waiting.
                        ptr      <= gnt_id + IDW'(1);
                        hold_cnt <= '0;
                        if (en && found) begin
                            gnt    <= id_to_onehot(win);
                            gnt_id <= win;
                        end else begin
                            gnt       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end else if (hold_up && en && found) begin
                        // Preempt: owner used its full hold budget and
                        // someone else is waiting.
                        ptr      <= gnt_id + IDW'(1);
                        hold_cnt <= '0;
                        gnt      <= id_to_onehot(win);
                        gnt_id   <= win;
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Saturate so a sole requester never wraps the count.
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: vector table plus hand-written reset sequences.
// Latency: expects registered outputs one clock after inputs are driven.
// Backpressure: n/a (bench).
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add_vec(input logic e, input logic [7:0] r,
                                    input logic [7:0] g, input logic [2:0] i,
                                    input string nm, input int reps);
        for (int k = 0; k < reps; k++) begin
            tbl.push_back('{e, r, g, i, nm});
        end
    endfunction

    // Pop the oldest expectation and compare against the current outputs.
    task automatic check_out();
        exp_t x;
        logic exp_vld;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
            n_bad++;
            return;
        end
        x = sb_q.pop_front();
        exp_vld = |x.gnt;
        n_vec++;
        if (gnt !== x.gnt || gnt_id !== x.id || gnt_valid !== exp_vld) begin
            n_bad++;
            $display("FAIL %s: got gnt=%h gnt_id=%0d gnt_valid=%b, want gnt=%h gnt_id=%0d gnt_valid=%b (t=%0t)",
                     x.name, gnt, gnt_id, gnt_valid, x.gnt, x.id, exp_vld, $time);
        end
    endtask

    // Drive on the falling edge, sample just after the next rising edge.
    task automatic step(input logic e, input logic [7:0] r,
                        input logic [7:0] g, input logic [2:0] i, input string nm);
        @(negedge clk);
        en  = e;
        req = r;
        sb_q.push_back('{g, i, nm});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        // Release/rotation/wrap/sole/enable scenarios, continuing from the
        // state left by the reset-release step (owner 0, ptr 0).
        add_vec(1, 8'h00, 8'h00, 3'd0, "rel_idle",     1);  // ptr -> 1
        add_vec(1, 8'h24, 8'h04, 3'd2, "rot_first",    4);
        add_vec(1, 8'h24, 8'h20, 3'd5, "rot_second",   4);  // ptr -> 3
        add_vec(1, 8'h24, 8'h04, 3'd2, "rot_back",     1);  // ptr -> 6
        add_vec(1, 8'h00, 8'h00, 3'd0, "rot_end",      1);  // ptr -> 3
        add_vec(1, 8'h81, 8'h80, 3'd7, "wrap_own7",    1);
        add_vec(1, 8'h01, 8'h01, 3'd0, "wrap_rel",     1);  // ptr -> 0
        add_vec(1, 8'h00, 8'h00, 3'd0, "wrap_idle",    1);  // ptr -> 1
        add_vec(1, 8'h08, 8'h08, 3'd3, "sole",        20);
        add_vec(1, 8'h00, 8'h00, 3'd0, "sole_end",     1);  // ptr -> 4
        add_vec(0, 8'h10, 8'h00, 3'd0, "en_block",     2);
        add_vec(1, 8'h10, 8'h10, 3'd4, "en_grant",     1);
        add_vec(0, 8'h50, 8'h10, 3'd4, "en_keep",      6);
        add_vec(0, 8'h40, 8'h00, 3'd0, "en_rel_idle",  1);  // ptr -> 5
        add_vec(0, 8'h40, 8'h00, 3'd0, "en_idle_hold", 1);
        add_vec(1, 8'h40, 8'h40, 3'd6, "en_resume",    1);
        add_vec(1, 8'h20, 8'h20, 3'd5, "handover",     1);  // ptr -> 7

        // Reset asserted with every requester active.
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{8'h00, 3'd0, "rst_hold"});
        check_out();

        // Release between edges with en already high.
        en = 1'b1;
        #2 rst_n = 1'b1;
        step(1, 8'hFF, 8'h01, 3'd0, "rst_release");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].name);
        end

        // Asynchronous reset while gnt=8'h20: outputs clear with no clock.
        #2 rst_n = 1'b0;
        #1;
        sb_q.push_back('{8'h00, 3'd0, "arst_now"});
        check_out();
        en  = 1'b1;
        req = 8'h81;
        @(posedge clk);
        #3 rst_n = 1'b1;
        // ptr back at 0 means 0 beats 7.
        step(1, 8'h81, 8'h01, 3'd0, "arst_restart");
        for (int i = 0; i < 3; i++) step(1, 8'h81, 8'h01, 3'd0, "pre_hold0");
        for (int i = 0; i < 4; i++) step(1, 8'h81, 8'h80, 3'd7, "pre_to7");
        step(1, 8'h81, 8'h01, 3'd0, "pre_wrap0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
